// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage register.
//   state_e   : occupancy state of a pipe_stage_skid instance
//   CTRL_*    : bit offsets of the EX/MEM control vector fields
//   occ_of()  : entry count held in a given state
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned OCC_W      = 2;

    // EX/MEM control vector layout
    localparam int unsigned CTRL_REGWRT     = 0;
    localparam int unsigned CTRL_MEMWRT     = 1;
    localparam int unsigned CTRL_READ       = 2;
    localparam int unsigned CTRL_RSLTSRC_LO = 3;
    localparam int unsigned CTRL_RSLTSRC_HI = 4;
    localparam int unsigned CTRL_FUNCT3_LO  = 5;
    localparam int unsigned CTRL_FUNCT3_HI  = 7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // Number of entries held in a given state
    function automatic logic [OCC_W-1:0] occ_of(input state_e s);
        case (s)
            ST_FULL: occ_of = OCC_W'(1);
            ST_SKID: occ_of = OCC_W'(2);
            default: occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + ctrl + data.
//   load_i  : capture ctrl_i/data_i and mark valid
//   clear_i : invalidate and zero ctrl (data held); wins over load_i
//   valid_o/ctrl_o/data_o : registered entry contents
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Entry register; ctrl is zeroed whenever the entry goes invalid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with flush and optional skid entry.
//   in_valid/in_ready/in_ctrl/in_data     : upstream handshake + payload
//   flush                                 : drop held and incoming content
//   out_valid/out_ready/out_ctrl/out_data : downstream handshake + payload
//   occ                                   : entries held (0..2)
// SKID=1 registers in_ready so a downstream stall never reaches upstream
// combinationally; SKID=0 is a single register with combinational in_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occ
);

    state_e             state_q, state_d;
    logic [OCC_W-1:0]   occ_q;
    logic               in_xfer;
    logic               main_load, main_clear, main_sel_skid;
    logic               skid_load, skid_clear;
    logic               skid_valid;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  main_ctrl_in;
    logic [DATA_W-1:0]  main_data_in;

    assign in_xfer = in_valid & in_ready;

    // Next-state and slot control
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_xfer) begin
                            main_load = 1'b1;
                        end else begin
                            main_clear = 1'b1;
                            state_d    = ST_EMPTY;
                        end
                    end else if (in_xfer && (SKID == 1)) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so the skid entry is the only source
                    if (out_ready) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                        state_d       = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_of(state_d);
        end
    end

    assign main_ctrl_in = main_sel_skid ? (skid_valid ? skid_ctrl : '0) : in_ctrl;
    assign main_data_in = main_sel_skid ? skid_data : in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (out_valid),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data)
    );

    generate
        if (SKID == 1) begin : g_skid
            logic in_ready_q;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (skid_load),
                .clear_i (skid_clear),
                .ctrl_i  (in_ctrl),
                .data_i  (in_data),
                .valid_o (skid_valid),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );

            // Registered ready: low only while both entries are occupied
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_SKID);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign in_ready   = ~out_valid | out_ready;
        end
    endgenerate

    assign occ = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a SKID=1 and a SKID=0 instance share
// the same stimulus; each has its own FIFO reference (capacity 2 and 1).
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_ctrl;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_ctrl;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;

    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   post_rst = 1'b0;
    bit   rdy_a, rdy_b;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .occ(a_occ)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occ(b_occ)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compare presented outputs against the head of each reference FIFO
    always @(negedge clk) begin
        if (mon_en) begin
            if (qa.size() == 0) begin
                chk("a out_valid idle", 64'(a_out_valid), 64'(0));
                chk("a out_ctrl idle", 64'(a_out_ctrl), 64'(0));
            end else begin
                chk("a out_valid", 64'(a_out_valid), 64'(1));
                chk("a out_ctrl", 64'(a_out_ctrl), 64'(qa[0].c));
                chk("a out_data", 64'(a_out_data), 64'(qa[0].d));
            end
            chk("a in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
            chk("a occ", 64'(a_occ), 64'(qa.size()));
            if (post_rst) chk("a out_data reset", 64'(a_out_data), 64'(0));
            if (qa.size() != 0 && out_ready) void'(qa.pop_front());

            if (qb.size() == 0) begin
                chk("b out_valid idle", 64'(b_out_valid), 64'(0));
                chk("b out_ctrl idle", 64'(b_out_ctrl), 64'(0));
            end else begin
                chk("b out_valid", 64'(b_out_valid), 64'(1));
                chk("b out_ctrl", 64'(b_out_ctrl), 64'(qb[0].c));
                chk("b out_data", 64'(b_out_data), 64'(qb[0].d));
            end
            chk("b in_ready", 64'(b_in_ready), 64'(qb.size() == 0 || out_ready));
            chk("b occ", 64'(b_occ), 64'(qb.size()));
            if (post_rst) chk("b out_data reset", 64'(b_out_data), 64'(0));
            if (qb.size() != 0 && out_ready) void'(qb.pop_front());
        end
    end

    // Drive one cycle of stimulus and record what the reference accepts
    task automatic drive(input bit v, input logic [7:0] c, input logic [31:0] d,
                         input bit ordy, input bit fl, input bit rn);
        ent_t e;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        rdy_a = (qa.size() < 2);
        rdy_b = (qb.size() == 0) || ordy;
        @(negedge clk);
        #1;
        post_rst = !rn;
        e.c = c;
        e.d = d;
        if (!rn || fl) begin
            qa.delete();
            qb.delete();
        end else if (v) begin
            if (rdy_a) qa.push_back(e);
            if (rdy_b) qb.push_back(e);
        end
    endtask

    initial begin
        // reset then stream
        drive(0, 8'h00, 32'h0, 1, 0, 0);
        drive(0, 8'h00, 32'h0, 1, 0, 0);
        mon_en = 1'b1;
        drive(1, 8'h11, 32'h10, 1, 0, 1);
        drive(1, 8'h12, 32'h14, 1, 0, 1);
        drive(1, 8'h13, 32'h18, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        // backpressure into skid, then drain
        drive(1, 8'h21, 32'hA, 0, 0, 1);
        drive(1, 8'h22, 32'hB, 0, 0, 1);
        drive(0, 8'h00, 32'h0, 0, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        // flush while two entries are held, with a new entry offered
        drive(1, 8'h31, 32'hA, 0, 0, 1);
        drive(1, 8'h32, 32'hB, 0, 0, 1);
        drive(1, 8'h33, 32'hC, 0, 1, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        // bubbles with non-zero ctrl on the bus
        drive(0, 8'hFF, 32'h55, 1, 0, 1);
        drive(0, 8'hFF, 32'h66, 0, 0, 1);
        drive(0, 8'hFF, 32'h77, 1, 0, 1);
        // single-register stall and same-cycle replace
        drive(1, 8'h41, 32'h40, 0, 0, 1);
        drive(1, 8'h42, 32'h44, 0, 0, 1);
        drive(1, 8'h43, 32'h48, 1, 0, 1);
        drive(1, 8'h44, 32'h4C, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        // reset during a stall with two entries held
        drive(1, 8'h51, 32'hD0, 0, 0, 1);
        drive(1, 8'h52, 32'hD4, 0, 0, 1);
        drive(0, 8'h00, 32'h0, 0, 0, 0);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) != 0);
        end
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0, 1);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, handshaked pipeline-stage register. It is the generalised successor of the fixed EX/MEM latch and is used between EX/MEM, MEM/WB and any future stage pair.
- Adds synchronous reset, valid/ready backpressure, flush (bubble insertion) and an optional one-entry skid buffer.
- A downstream stall does not combinationally reach upstream ready.
- Control bits are zeroed whenever a slot is invalid, so a bubble never writes a register or memory.

Parameters:
DATA_W, 32, width of datapath payload (ALU result, store data, pc+4, etc. concatenated by the instantiator)
CTRL_W, 8, width of control payload (regWrt, memWrt, read, rsltSrc[1:0], funct3[2:0])
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  upstream stage has a valid instruction
in_ready  out  1  this stage accepts in_* this cycle
in_ctrl  in  CTRL_W  upstream control payload
in_data  in  DATA_W  upstream datapath payload
flush  in  1  kill all held and incoming content (branch mispredict / trap)
out_valid  out  1  out_* holds a valid instruction
out_ready  in  1  downstream accepts out_* this cycle
out_ctrl  out  CTRL_W  control to next stage; all-zero when out_valid=0
out_data  out  DATA_W  datapath to next stage
occ  out  2  entries held: 0, 1, or 2 (2 only if SKID=1)

Behaviour:
- Handshake and latency
  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
  - Latency is 1 cycle: in_* captured at edge N appears on out_* after edge N.
  - out_* are driven directly from the main register; there is no combinational input-to-output path.
- States: EMPTY (occ=0), FULL (main valid, occ=1), SKID (main+skid valid, occ=2; SKID=1 only).
- in_ready
  - SKID=1: in_ready = (state != SKID). It is registered and independent of out_ready.
  - SKID=0: in_ready = ~out_valid | out_ready.
- Transitions (no flush):
  - EMPTY: in_valid -> main<=in, FULL; else stay.
  - FULL, out_ready & in_valid -> main<=in, FULL (back-to-back, full throughput).
  - FULL, out_ready & ~in_valid -> EMPTY.
  - FULL, ~out_ready & in_valid -> SKID=1: skid<=in, go to SKID. SKID=0: not reachable, because in_ready=0.
  - FULL, ~out_ready & ~in_valid -> hold.
  - SKID: out_ready -> main<=skid, FULL. in_ready=0 this cycle, so no simultaneous load. ~out_ready -> hold.
- Ordering: strictly FIFO; the skid entry always leaves after the main entry.
- Flush (highest priority below reset):
  - Next state is EMPTY and occ becomes 0.
  - Both entries are dropped, and any in_* offered that cycle is dropped even if in_ready=1.
  - out_valid=0 and out_ctrl=0 from the next cycle; out_data holds its last value (don't-care).
  - flush with out_ready=1 in the same cycle: the current out_* still counts as transferred downstream that cycle. Downstream owns the decision to ignore it.
- Reset (rst_n=0 at an edge, including mid-transfer or in SKID):
  - state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, occ=0, skid contents=0.
  - in_ready=1 after reset for SKID=1; for SKID=0 it follows its formula, which gives 1.
- Ctrl gating: ctrl registers are written with 0 whenever the corresponding entry becomes invalid. out_ctrl=0 whenever out_valid=0 is an invariant.
- Holding: payload registers are only written on an accepted transfer. They never change while the stage is held with ~out_ready.

Decomposition:
- Package pipe_pkg:
  - state enum {ST_EMPTY, ST_FULL, ST_SKID}
  - localparam field offsets for the EX/MEM ctrl vector (CTRL_REGWRT=0, CTRL_MEMWRT=1, CTRL_READ=2, CTRL_RSLTSRC=4:3, CTRL_FUNCT3=7:5)
  - default widths
- Sub-module pipe_slot: one entry holding valid + ctrl + data, with load, clear (ctrl<=0, valid<=0) and reset. It is instantiated twice: main, plus skid under generate when SKID=1.

Test Plan:
1. Reset then stream: rst_n=0 for 2 cycles, then in_valid=1 with in_data=0x10,0x14,0x18 and out_ready=1 -> out_data 0x10,0x14,0x18 on the following 3 cycles, out_valid=1, in_ready=1 throughout, occ=1.
2. Backpressure/skid (SKID=1): in_data 0xA then 0xB, out_ready=0 from cycle 1 -> occ=2, in_ready=0; after out_ready=1 -> outputs 0xA then 0xB, with no loss or duplication.
3. Flush in SKID state: occ=2, flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0, out_ctrl=0x00, occ=0, in_ready=1; 0xC is never emitted.
4. Bubble ctrl gating: in_ctrl=0xFF with in_valid=0 -> out_ctrl stays 0x00 and out_valid=0.
5. SKID=0 variant: out_valid=1 with out_ready=0 -> in_ready=0 combinationally; out_ready=1 and in_valid=1 -> new entry accepted the same cycle.
6. Mid-stall reset: occ=2, rst_n=0 for one edge -> all outputs 0 next cycle, occ=0.
